// File: rtl/inst_sequencer_if.sv
// Signal bundle between the instruction sequencer and the rest of the 4-bit core.
// The master side is the sequencer. The slave side is its environment: the data bus, the flags and the PC stack.
interface inst_sequencer_if;
   logic [3:0] data;
   logic       test;
   logic       carry_flag;
   logic       acc_zero;
   logic [2:0] cycle;
   logic       sync;
   logic       halt;
   logic [3:0] opr;
   logic [3:0] opa;
   logic [3:0] inst_operand;
   logic       second_word;
   logic [3:0] reg_sel;
   logic [1:0] pc_next_sel;
   logic [2:0] pc_write_enable;

   modport master (
      input  data, test, carry_flag, acc_zero,
      output cycle, sync, halt, opr, opa, inst_operand, second_word,
             reg_sel, pc_next_sel, pc_write_enable
   );

   modport slave (
      output data, test, carry_flag, acc_zero,
      input  cycle, sync, halt, opr, opa, inst_operand, second_word,
             reg_sel, pc_next_sel, pc_write_enable
   );
endinterface

// File: rtl/inst_sequencer.sv
// Instruction-cycle phase counter and OPR/OPA latch. Also holds the two-word and jump tracking,
// and drives the PC-update controls for the PC stack.
module inst_sequencer #(
   parameter int NUM_CYCLES = 8
) (
   input logic               clock,
   input logic               reset,
   inst_sequencer_if.master  bus
);

   localparam logic [2:0] LAST_CYCLE  = 3'(NUM_CYCLES - 1);
   localparam logic [3:0] OPR_MISC    = 4'h0;
   localparam logic [3:0] OPR_JCN     = 4'h1;
   localparam logic [3:0] OPR_FIN_JIN = 4'h3;
   localparam logic [3:0] OPR_JUN     = 4'h4;

   typedef enum logic { ST_RUN, ST_HALT } state_t;
   typedef enum logic [1:0] { SEL_DATA = 2'd0, SEL_REG = 2'd1, SEL_INST = 2'd2 } pc_sel_t;

   state_t     state, state_next;
   logic [2:0] cycle;
   logic [3:0] opr, opa;
   logic       second_word, jump_taken;
   logic       is_jun, is_jcn, is_jin, is_hlt, jcn_cond, end_of_frame;
   pc_sel_t    pc_sel;
   logic [2:0] pc_we;
   logic [3:0] reg_sel;

   assign is_jun       = (opr == OPR_JUN);
   assign is_jcn       = (opr == OPR_JCN);
   assign is_jin       = (opr == OPR_FIN_JIN) && opa[0];
   assign is_hlt       = (opr == OPR_MISC) && (opa == 4'h1);
   assign jcn_cond     = (opa[0] & bus.test) | (opa[1] & bus.carry_flag) | (opa[2] & bus.acc_zero);
   assign end_of_frame = (cycle == LAST_CYCLE);

   always_ff @(posedge clock) begin
      if (reset) state <= ST_RUN;
      else       state <= state_next;
   end

   // HALT is sticky. Only reset leaves it.
   always_comb begin
      state_next = state;
      if (state == ST_RUN && end_of_frame && !second_word && is_hlt)
         state_next = ST_HALT;
   end

   // NOTE: sequential state uses non-blocking assignments. Every register then samples
   // the pre-edge values of the others, and the result does not depend on statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         cycle       <= '0;
         opr         <= '0;
         opa         <= '0;
         second_word <= 1'b0;
         jump_taken  <= 1'b0;
      end else if (state == ST_RUN) begin
         cycle <= end_of_frame ? 3'd0 : cycle + 3'd1;
         if (!second_word && cycle == 3'd3) opr <= bus.data;
         if (!second_word && cycle == 3'd4) opa <= bus.data;
         if (!second_word && cycle == 3'd5)
            jump_taken <= is_jun | (is_jcn & (jcn_cond ^ opa[3]));
         if (end_of_frame)
            second_word <= !second_word && (is_jun || is_jcn);
      end
   end

   // NOTE: every output of this block gets a default first. Otherwise the paths that
   // do not assign it would infer a latch.
   always_comb begin
      pc_sel  = SEL_DATA;
      pc_we   = 3'b000;
      reg_sel = 4'h0;
      if (state == ST_RUN) begin
         if (second_word && jump_taken) begin
            if (cycle == 3'd3)      pc_we = 3'b010;
            else if (cycle == 3'd4) pc_we = 3'b001;
         end else if (!second_word && is_jin) begin
            if (cycle == 3'd5) begin
               reg_sel = {opa[3:1], 1'b0};
               pc_sel  = SEL_REG;
               pc_we   = 3'b010;
            end else if (cycle == 3'd6) begin
               reg_sel = {opa[3:1], 1'b1};
               pc_sel  = SEL_REG;
               pc_we   = 3'b001;
            end
         end
      end
   end

   assign bus.cycle           = cycle;
   assign bus.sync            = (cycle == LAST_CYCLE);
   assign bus.halt            = (state == ST_HALT);
   assign bus.opr             = opr;
   assign bus.opa             = opa;
   assign bus.inst_operand    = opa;
   assign bus.second_word     = second_word;
   assign bus.reg_sel         = reg_sel;
   assign bus.pc_next_sel     = pc_sel;
   assign bus.pc_write_enable = pc_we;

endmodule
